// File: rtl/rect_fill_pkg.sv
// rect_fill_pkg: shared state encoding, default frame size and colour constants
package rect_fill_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;
    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;
endpackage

// File: rtl/rect_fill_engine_pixel_tick_gen.sv
// pixel_tick_gen: divides clk by RATE_DIV while enabled, one-cycle tick at count RATE_DIV-1
module pixel_tick_gen #(
    parameter int RATE_DIV = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = RATE_DIV > 1 ? $clog2(RATE_DIV) : 1;
    logic [CW-1:0] cnt;
    assign tick = en && cnt == CW'(RATE_DIV - 1);
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else if (clr || tick) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/rect_fill_engine.sv
// rect_fill_engine: fills a clipped rectangle of the frame at one pixel per RATE_DIV clocks.
// Define FILL_PATTERN_EN for a fill/alt checkerboard instead of a solid colour.
module rect_fill_engine
    import rect_fill_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int RATE_DIV = 25
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [X_W-1:0]      rect_x0,
    input  logic [Y_W-1:0]      rect_y0,
    input  logic [X_W-1:0]      rect_w,
    input  logic [Y_W-1:0]      rect_h,
    input  logic [COLOUR_W-1:0] fill_colour,
    input  logic [COLOUR_W-1:0] alt_colour,
    output logic                busy,
    output logic                done,
    output logic                plot,
    output logic [X_W-1:0]      VGA_x,
    output logic [Y_W-1:0]      VGA_y,
    output logic [COLOUR_W-1:0] VGA_Colour
);
    state_t state, nxt;
    logic [X_W-1:0] x0_q, xe_q, cur_x, x_end;
    logic [Y_W-1:0] y0_q, ye_q, cur_y, y_end;
    logic [X_W:0] x_sum;
    logic [Y_W:0] y_sum;
    logic [COLOUR_W-1:0] fill_q, pix_colour;
    logic accept, empty, tick, adv, last, busy_d, done_d, plot_d;

    // clip in one extra bit so x0+w never wraps before the min()
    assign x_sum  = {1'b0, rect_x0} + {1'b0, rect_w};
    assign y_sum  = {1'b0, rect_y0} + {1'b0, rect_h};
    assign x_end  = x_sum > (X_W+1)'(SCREEN_W) ? X_W'(SCREEN_W - 1) : X_W'(x_sum - 1'b1);
    assign y_end  = y_sum > (Y_W+1)'(SCREEN_H) ? Y_W'(SCREEN_H - 1) : Y_W'(y_sum - 1'b1);
    assign empty  = rect_w == '0 || rect_h == '0 || int'(rect_x0) >= SCREEN_W || int'(rect_y0) >= SCREEN_H;
    assign accept = state == IDLE && start && !abort;
    assign adv    = state == RUN && tick && !abort;
    assign last   = cur_x == xe_q && cur_y == ye_q;

    pixel_tick_gen #(.RATE_DIV(RATE_DIV)) u_tick (
        .clk  (clk),
        .reset(reset),
        .clr  (state != RUN),
        .en   (state == RUN),
        .tick (tick)
    );

    always_comb begin
        nxt = abort ? IDLE :
              state == IDLE ? (start ? (empty ? FIN : RUN) : IDLE) :
              state == RUN  ? (tick && last ? FIN : RUN) : IDLE;
    end

    always_comb begin
        busy_d = nxt != IDLE;
        done_d = state == FIN && !abort;
        plot_d = adv;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            plot       <= 1'b0;
            VGA_x      <= '0;
            VGA_y      <= '0;
            VGA_Colour <= '0;
        end else begin
            state <= nxt;
            busy  <= busy_d;
            done  <= done_d;
            plot  <= plot_d;
            if (adv) begin
                VGA_x      <= cur_x;
                VGA_y      <= cur_y;
                VGA_Colour <= pix_colour;
            end
        end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            x0_q   <= '0;
            y0_q   <= '0;
            xe_q   <= '0;
            ye_q   <= '0;
            cur_x  <= '0;
            cur_y  <= '0;
            fill_q <= '0;
        end else if (accept) begin
            x0_q   <= rect_x0;
            y0_q   <= rect_y0;
            xe_q   <= x_end;
            ye_q   <= y_end;
            cur_x  <= rect_x0;
            cur_y  <= rect_y0;
            fill_q <= fill_colour;
        end else if (adv) begin
            cur_x <= cur_x == xe_q ? x0_q : cur_x + 1'b1;
            cur_y <= cur_x == xe_q ? cur_y + 1'b1 : cur_y;
        end

`ifdef FILL_PATTERN_EN
    logic [COLOUR_W-1:0] alt_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) alt_q <= '0;
        else if (accept) alt_q <= alt_colour;
    assign pix_colour = (cur_x[0] ^ cur_y[0]) ? alt_q : fill_q;
`else
    logic unused_alt;
    assign unused_alt = ^alt_colour;
    assign pix_colour = fill_q;
`endif
endmodule

// File: tb/tb_rect_fill_engine.sv
// tb_rect_fill_engine: three engines (RATE_DIV 1, 2, 25) checked against a pixel scoreboard
module tb_rect_fill_engine;
    localparam int N = 3;
    localparam int RDS[N] = '{1, 2, 25};

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        int dut;
        int x0, y0, w, h, fc, ac;
        int exp_n;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [N-1:0] start = '0;
    logic [N-1:0] abort = '0;
    logic [7:0] rect_x0 = '0, rect_w = '0;
    logic [6:0] rect_y0 = '0, rect_h = '0;
    logic [2:0] fill_colour = '0, alt_colour = '0;
    logic busy[N], done[N], plot[N];
    logic [7:0] vx[N];
    logic [6:0] vy[N];
    logic [2:0] vc[N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        rect_fill_engine #(.RATE_DIV(RDS[g])) dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start[g]),
            .abort      (abort[g]),
            .rect_x0    (rect_x0),
            .rect_y0    (rect_y0),
            .rect_w     (rect_w),
            .rect_h     (rect_h),
            .fill_colour(fill_colour),
            .alt_colour (alt_colour),
            .busy       (busy[g]),
            .done       (done[g]),
            .plot       (plot[g]),
            .VGA_x      (vx[g]),
            .VGA_y      (vy[g]),
            .VGA_Colour (vc[g])
        );
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    pix_t q[N][$];
    int plots[N], dones[N], prev_plot[N], first_plot[N], last_plot[N], done_cyc[N];

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    pix_t e;
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (plot[i]) begin
                plots[i]++;
                if (prev_plot[i] >= 0) check($sformatf("gap_dut%0d", i), cyc - prev_plot[i], RDS[i]);
                else first_plot[i] = cyc;
                prev_plot[i] = cyc;
                last_plot[i] = cyc;
                if (q[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_plot dut%0d: got (%0d,%0d) colour %0d, expected no plot", i, vx[i], vy[i], vc[i]);
                end else begin
                    e = q[i].pop_front();
                    check($sformatf("x_dut%0d", i), int'(vx[i]), int'(e.x));
                    check($sformatf("y_dut%0d", i), int'(vy[i]), int'(e.y));
                    check($sformatf("colour_dut%0d", i), int'(vc[i]), int'(e.c));
                end
            end
            if (done[i]) begin
                dones[i]++;
                done_cyc[i] = cyc;
            end
        end
    end

    task automatic push_rect(int i, int x0, int y0, int w, int h, int fc, int ac);
        int xe, ye, c;
        pix_t p;
        if (w == 0 || h == 0 || x0 >= 160 || y0 >= 120) return;
        xe = (x0 + w > 160 ? 160 : x0 + w) - 1;
        ye = (y0 + h > 120 ? 120 : y0 + h) - 1;
        for (int y = y0; y <= ye; y++)
            for (int x = x0; x <= xe; x++) begin
                c = fc;
`ifdef FILL_PATTERN_EN
                if (((x ^ y) & 1) != 0) c = ac;
`endif
                p.x = 8'(x);
                p.y = 7'(y);
                p.c = 3'(c);
                q[i].push_back(p);
            end
    endtask

    task automatic set_rect(int x0, int y0, int w, int h, int fc, int ac);
        rect_x0 = 8'(x0);
        rect_y0 = 7'(y0);
        rect_w = 8'(w);
        rect_h = 7'(h);
        fill_colour = 3'(fc);
        alt_colour = 3'(ac);
    endtask

    task automatic do_start(int i, int x0, int y0, int w, int h, int fc, int ac, output int s);
        @(posedge clk);
        #1;
        set_rect(x0, y0, w, h, fc, ac);
        push_rect(i, x0, y0, w, h, fc, ac);
        prev_plot[i] = -1;
        start[i] = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        start[i] = 1'b0;
    endtask

    task automatic wait_done(int i, int budget);
        int d0 = dones[i];
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (dones[i] != d0) return;
        end
        checks++;
        errors++;
        $display("FAIL timeout_done dut%0d: no done within %0d cycles", i, budget);
    endtask

    task automatic wait_plots(int i, int target, int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (plots[i] >= target) return;
        end
        checks++;
        errors++;
        $display("FAIL timeout_plot dut%0d: %0d plots, expected %0d", i, plots[i], target);
    endtask

    task automatic check_zero(int i, string tag);
        check($sformatf("%s_busy%0d", tag, i), int'(busy[i]), 0);
        check($sformatf("%s_done%0d", tag, i), int'(done[i]), 0);
        check($sformatf("%s_plot%0d", tag, i), int'(plot[i]), 0);
        check($sformatf("%s_x%0d", tag, i), int'(vx[i]), 0);
        check($sformatf("%s_y%0d", tag, i), int'(vy[i]), 0);
        check($sformatf("%s_c%0d", tag, i), int'(vc[i]), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[7];
    initial begin
        int s, p0, d0, i;
        vecs[0] = '{0, 0, 0, 160, 120, 0, 0, 19200};
        vecs[1] = '{2, 150, 115, 20, 10, 4, 0, 50};
        vecs[2] = '{2, 5, 5, 0, 3, 2, 0, 0};
        vecs[3] = '{2, 200, 5, 4, 4, 1, 0, 0};
        vecs[4] = '{1, 0, 0, 2, 2, 1, 6, 4};
        vecs[5] = '{1, 158, 118, 3, 3, 7, 2, 4};
        vecs[6] = '{1, 10, 120, 3, 3, 5, 0, 0};
        for (int k = 0; k < N; k++) prev_plot[k] = -1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) check_zero(k, "reset");

        foreach (vecs[v]) begin
            i = vecs[v].dut;
            p0 = plots[i];
            d0 = dones[i];
            do_start(i, vecs[v].x0, vecs[v].y0, vecs[v].w, vecs[v].h, vecs[v].fc, vecs[v].ac, s);
            wait_done(i, vecs[v].exp_n * RDS[i] + 50);
            check($sformatf("v%0d_plots", v), plots[i] - p0, vecs[v].exp_n);
            check($sformatf("v%0d_dones", v), dones[i] - d0, 1);
            if (vecs[v].exp_n > 0) begin
                check($sformatf("v%0d_first_latency", v), first_plot[i] - s, RDS[i]);
                check($sformatf("v%0d_done_after_last", v), done_cyc[i] - last_plot[i], 1);
            end else
                check($sformatf("v%0d_empty_done", v), done_cyc[i] - s, 1);
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_busy_low", v), int'(busy[i]), 0);
            check($sformatf("v%0d_queue_left", v), q[i].size(), 0);
            check($sformatf("v%0d_single_done", v), dones[i] - d0, 1);
        end

        // abort after the fifth plot, then a clean restart
        p0 = plots[1];
        d0 = dones[1];
        do_start(1, 20, 30, 4, 4, 5, 0, s);
        wait_plots(1, p0 + 5, 100);
        abort[1] = 1'b1;
        @(posedge clk);
        #1;
        abort[1] = 1'b0;
        check("abort_busy", int'(busy[1]), 0);
        q[1].delete();
        repeat (10) @(negedge clk);
        check("abort_plots", plots[1] - p0, 5);
        check("abort_no_done", dones[1] - d0, 0);
        p0 = plots[1];
        do_start(1, 20, 30, 4, 4, 5, 0, s);
        wait_done(1, 100);
        check("restart_plots", plots[1] - p0, 16);
        check("restart_queue", q[1].size(), 0);

        // a second start while busy must not disturb the first fill
        p0 = plots[1];
        d0 = dones[1];
        do_start(1, 10, 10, 3, 2, 2, 0, s);
        repeat (3) @(posedge clk);
        #1;
        set_rect(50, 50, 5, 5, 7, 3);
        start[1] = 1'b1;
        @(posedge clk);
        #1;
        start[1] = 1'b0;
        wait_done(1, 100);
        check("busy_start_plots", plots[1] - p0, 6);
        check("busy_start_dones", dones[1] - d0, 1);
        check("busy_start_queue", q[1].size(), 0);

        // async reset mid-fill
        p0 = plots[2];
        d0 = dones[2];
        do_start(2, 0, 0, 4, 4, 3, 0, s);
        wait_plots(2, p0 + 2, 200);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_zero(2, "async_reset");
        q[2].delete();
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        repeat (150) @(negedge clk);
        check("reset_no_done", dones[2] - d0, 0);
        check("reset_no_more_plots", plots[2] - p0, 2);
        check("reset_busy", int'(busy[2]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
